spm_dma: RTL and testbench
==========================

SPM_DMA -- requirements
Module: spm_dma

Interface
REQ-001 Parameters SHALL be: DW, default 32, data word width; SAW, default 12, SPM word address width; BAW, default 30, bus word address width.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, in order (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge
- reset  in  1  async active-low reset
- start  in  1  one-cycle pulse; launch transfer
- dir  in  1  0 = bus->SPM, 1 = SPM->bus; sampled at start
- abort  in  1  one-cycle pulse; stop after current beat
- bus_base  in  BAW  first bus word address; sampled at start
- spm_base  in  SAW  first SPM word address; sampled at start
- len  in  SAW+1  word count; sampled at start
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- err  out  1  last transfer aborted; held until next start
- bus_req  out  1  bus request
- bus_grnt  in  1  bus grant
- bus_as_  out  1  address strobe, active-low
- bus_rw  out  1  1 = read, 0 = write
- bus_addr  out  BAW  bus word address
- bus_wr_data  out  DW  bus write data
- bus_rd_data  in  DW  bus read data; valid while bus_rdy_ = 0
- bus_rdy_  in  1  beat complete, active-low
- spm_addr  out  SAW  SPM port address
- spm_we  out  1  SPM write enable
- spm_wr_data  out  DW  SPM write data
- spm_rd_data  in  DW  SPM read data; registered, valid one cycle after spm_addr is presented

Function
REQ-004 The FSM SHALL have states IDLE, REQ, SPM_RD, BUS_ACC, SPM_WR and FIN; all outputs SHALL be registered.
REQ-005 In IDLE, start SHALL latch dir, bus_base, spm_base and len, clear err, and set busy the next cycle.
- len = 0: go to FIN without asserting bus_req.
- len > 0: go to REQ.
REQ-006 In REQ, bus_req SHALL be 1; on bus_grnt = 1 go to BUS_ACC when dir = 0, or to SPM_RD when dir = 1.
REQ-007 bus_req SHALL stay 1 from REQ until FIN for the whole transfer; it is not released between beats.
REQ-008 In SPM_RD, the block SHALL drive spm_addr for exactly one cycle, then capture spm_rd_data into bus_wr_data and go to BUS_ACC.
REQ-009 In BUS_ACC, the block SHALL drive bus_as_ = 0, bus_addr and bus_rw = ~dir until the cycle in which bus_rdy_ = 0, which completes the beat.
REQ-010 On beat completion with dir = 0, the block SHALL latch bus_rd_data and go to SPM_WR.
REQ-011 In SPM_WR, the block SHALL assert spm_we = 1 for exactly one cycle with the latched data, then advance.
REQ-012 Advance SHALL mean: bus and SPM addresses +1 and remaining count -1.
- Count reaches 0: go to FIN.
- Otherwise: go to BUS_ACC when dir = 0, or to SPM_RD when dir = 1.
REQ-013 SPM addresses SHALL wrap modulo 2^SAW; bus addresses SHALL wrap modulo 2^BAW.
REQ-014 In FIN, the block SHALL pulse done = 1 for one cycle, drop bus_req and busy, and return to IDLE.
REQ-015 start SHALL be ignored while busy = 1.
REQ-016 abort in IDLE SHALL be ignored.
REQ-017 abort while busy SHALL be recorded, and behaviour depends on state:
- REQ: go to FIN at once.
- Otherwise: finish the in-flight beat, including its SPM write when dir = 0, then go to FIN.
- In all cases: set err = 1 and pulse done.
REQ-018 abort and start in the same cycle while idle SHALL start the transfer and discard the abort.
REQ-019 Outside BUS_ACC, bus_as_ SHALL be 1; spm_we SHALL be 0 except in SPM_WR.

Reset
REQ-020 reset = 0 SHALL immediately force IDLE, even mid-transfer.
REQ-021 During and after reset, the following SHALL hold:
- busy = done = err = bus_req = spm_we = 0.
- bus_as_ = 1, bus_rw = 1.
- All address, data and counter registers = 0.

Verification
REQ-022 bus->SPM: start, dir=0, bus_base=0x100, spm_base=0x010, len=3, grant after 2 cycles, bus_rdy_ in the first access cycle returning A,B,C -> SPM words 0x010..0x012 = A,B,C; done pulse; err=0; exactly 3 spm_we cycles.
REQ-023 SPM->bus: SPM words 0xFFE,0xFFF,0x000 = X,Y,Z; start dir=1, spm_base=0xFFE, len=3, bus_base=0x200 -> bus writes X@0x200, Y@0x201, Z@0x202 (SPM wrap).
REQ-024 len=0 -> done pulses 2 cycles after start; bus_req never asserted; SPM untouched.
REQ-025 abort during the 2nd beat of len=8 (dir=0), bus_rdy_ delayed 3 cycles -> the 2nd beat completes and is written to SPM; no 3rd bus_as_; done with err=1.
REQ-026 reset low mid-BUS_ACC -> bus_as_=1, bus_req=0, busy=0 asynchronously; a new start after reset runs normally.
REQ-027 start pulsed while busy -> ignored; latched parameters unchanged; a single done pulse.

Source files
------------

// File: rtl/spm_dma.sv
// spm_dma: single-channel DMA between a scratch-pad memory (SPM) and a system bus.
//
// Moves len words in one direction, chosen by dir (0 = bus->SPM, 1 = SPM->bus).
// The bus is held (bus_req) for the whole transfer. Every output comes from a register.
//
// Ports:
//   clk, reset                    clock and asynchronous active-low reset
//   start, dir, abort             control inputs
//   bus_base, spm_base, len       transfer parameters, sampled when start is accepted
//   busy, done, err               status; done is a one-cycle pulse
//   bus_req, bus_grnt             bus arbitration
//   bus_as_, bus_rw, bus_addr     bus address phase (bus_as_ is active-low)
//   bus_wr_data, bus_rd_data      bus data
//   bus_rdy_                      beat complete, active-low
//   spm_addr, spm_we, spm_wr_data SPM port; the read data arrives one cycle after the address
//   spm_rd_data
module spm_dma #(
  parameter int unsigned DW  = 32,
  parameter int unsigned SAW = 12,
  parameter int unsigned BAW = 30
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           dir,
  input  logic           abort,
  input  logic [BAW-1:0] bus_base,
  input  logic [SAW-1:0] spm_base,
  input  logic [SAW:0]   len,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic           bus_req,
  input  logic           bus_grnt,
  output logic           bus_as_,
  output logic           bus_rw,
  output logic [BAW-1:0] bus_addr,
  output logic [DW-1:0]  bus_wr_data,
  input  logic [DW-1:0]  bus_rd_data,
  input  logic           bus_rdy_,
  output logic [SAW-1:0] spm_addr,
  output logic           spm_we,
  output logic [DW-1:0]  spm_wr_data,
  input  logic [DW-1:0]  spm_rd_data
);

  typedef enum logic [2:0] {StIdle, StReq, StSpmRd, StBusAcc, StSpmWr, StFin} state_e;

  localparam logic [SAW:0]   CntOne = (SAW + 1)'(1);
  localparam logic [BAW-1:0] BusInc = BAW'(1);
  localparam logic [SAW-1:0] SpmInc = SAW'(1);

  state_e         state_q;
  logic           dir_q, abort_q, rd_ph_q;
  logic [SAW:0]   cnt_q;
  logic           busy_q, done_q, err_q, bus_req_q, bus_as_q, bus_rw_q, spm_we_q;
  logic [BAW-1:0] bus_addr_q;
  logic [SAW-1:0] spm_addr_q;
  logic [DW-1:0]  bus_wr_data_q, spm_wr_data_q;

  logic advance, last_beat;

  // A beat ends after its SPM write (bus->SPM) or on bus completion (SPM->bus).
  always_comb begin
    advance   = (state_q == StSpmWr) || ((state_q == StBusAcc) && !bus_rdy_ && dir_q);
    last_beat = (cnt_q == CntOne) || abort || abort_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      dir_q         <= 1'b0;
      abort_q       <= 1'b0;
      rd_ph_q       <= 1'b0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      bus_req_q     <= 1'b0;
      bus_as_q      <= 1'b1;
      bus_rw_q      <= 1'b1;
      spm_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      spm_addr_q    <= '0;
      bus_wr_data_q <= '0;
      spm_wr_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort && busy_q) abort_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            dir_q      <= dir;
            bus_rw_q   <= ~dir;
            bus_addr_q <= bus_base;
            spm_addr_q <= spm_base;
            cnt_q      <= len;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            if (len == '0) begin
              state_q <= StFin;
            end else begin
              state_q   <= StReq;
              bus_req_q <= 1'b1;
            end
          end
        end
        StReq: begin
          if (abort) begin
            state_q <= StFin;
          end else if (bus_grnt) begin
            if (dir_q) begin
              state_q <= StSpmRd;
              rd_ph_q <= 1'b0;
            end else begin
              state_q  <= StBusAcc;
              bus_as_q <= 1'b0;
            end
          end
        end
        StSpmRd: begin
          // First cycle presents the address, second captures the registered read data.
          if (!rd_ph_q) begin
            rd_ph_q <= 1'b1;
          end else begin
            bus_wr_data_q <= spm_rd_data;
            bus_as_q      <= 1'b0;
            state_q       <= StBusAcc;
          end
        end
        StBusAcc: begin
          if (!bus_rdy_) begin
            bus_as_q <= 1'b1;
            if (!dir_q) begin
              spm_wr_data_q <= bus_rd_data;
              spm_we_q      <= 1'b1;
              state_q       <= StSpmWr;
            end
          end
        end
        StSpmWr: begin
          spm_we_q <= 1'b0;
        end
        StFin: begin
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          bus_req_q <= 1'b0;
          err_q     <= abort_q;
          abort_q   <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (advance) begin
        bus_addr_q <= bus_addr_q + BusInc;
        spm_addr_q <= spm_addr_q + SpmInc;
        cnt_q      <= cnt_q - CntOne;
        if (last_beat) begin
          state_q <= StFin;
        end else if (dir_q) begin
          state_q <= StSpmRd;
          rd_ph_q <= 1'b0;
        end else begin
          state_q  <= StBusAcc;
          bus_as_q <= 1'b0;
        end
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign bus_req     = bus_req_q;
  assign bus_as_     = bus_as_q;
  assign bus_rw      = bus_rw_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;
  assign spm_addr    = spm_addr_q;
  assign spm_we      = spm_we_q;
  assign spm_wr_data = spm_wr_data_q;

endmodule

// File: tb/tb_spm_dma.sv
// Bench for spm_dma. It models a synchronous SPM and a bus slave with programmable grant and
// ready delays, and checks each transfer against a word-level model of the expected memory
// contents and bus writes.
module tb_spm_dma;
  localparam int unsigned DW       = 32;
  localparam int unsigned SAW      = 12;
  localparam int unsigned BAW      = 30;
  localparam int unsigned SpmWords = 1 << SAW;

  logic           clk      = 1'b0;
  logic           reset    = 1'b0;
  logic           start    = 1'b0;
  logic           dir      = 1'b0;
  logic           abort    = 1'b0;
  logic [BAW-1:0] bus_base = '0;
  logic [SAW-1:0] spm_base = '0;
  logic [SAW:0]   len      = '0;
  logic           busy, done, err, bus_req, bus_as_, bus_rw, spm_we;
  logic           bus_grnt    = 1'b0;
  logic           bus_rdy_    = 1'b1;
  logic [DW-1:0]  bus_rd_data = '0;
  logic [BAW-1:0] bus_addr;
  logic [DW-1:0]  bus_wr_data, spm_wr_data, spm_rd_data;
  logic [SAW-1:0] spm_addr;

  always #5 clk = ~clk;

  spm_dma #(.DW(DW), .SAW(SAW), .BAW(BAW)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .abort(abort),
    .bus_base(bus_base), .spm_base(spm_base), .len(len),
    .busy(busy), .done(done), .err(err),
    .bus_req(bus_req), .bus_grnt(bus_grnt), .bus_as_(bus_as_), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .bus_rdy_(bus_rdy_), .spm_addr(spm_addr), .spm_we(spm_we),
    .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data)
  );

  // ---------------- environment ----------------
  logic [DW-1:0] spm_mem    [SpmWords];
  logic [DW-1:0] spm_shadow [SpmWords];
  logic [DW-1:0] spm_ref    [SpmWords];
  bit            load_en = 1'b0;

  always @(posedge clk) begin
    if (load_en) begin
      for (int k = 0; k < SpmWords; k++) spm_mem[k] <= spm_shadow[k];
    end else if (spm_we) begin
      spm_mem[spm_addr] <= spm_wr_data;
    end
    spm_rd_data <= spm_mem[spm_addr];
  end

  logic [DW-1:0] salt = '0;
  int grnt_delay = 0, rdy_delay = 0;
  int done_cnt = 0, we_cnt = 0, req_cyc = 0, as_starts = 0, req_wait = 0, acc_wait = 0;
  bit as_prev = 1'b1;
  logic [BAW-1:0] bw_addr[$];
  logic [DW-1:0]  bw_data[$];

  function automatic logic [DW-1:0] bus_val(input logic [BAW-1:0] a);
    return (DW'(a) * 32'h9E37_79B1) ^ salt;
  endfunction

  // Bus slave and activity monitors, all evaluated on the falling edge.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (spm_we) we_cnt++;
    if (bus_req) req_cyc++;
    if (!bus_as_ && as_prev) as_starts++;
    as_prev = bus_as_;
    bus_grnt = bus_req && (req_wait >= grnt_delay);
    req_wait = bus_req ? req_wait + 1 : 0;
    if (!bus_as_ && acc_wait >= rdy_delay) begin
      bus_rdy_    = 1'b0;
      bus_rd_data = bus_val(bus_addr);
      if (!bus_rw) begin
        bw_addr.push_back(bus_addr);
        bw_data.push_back(bus_wr_data);
      end
    end else begin
      bus_rdy_    = 1'b1;
      bus_rd_data = '0;
    end
    acc_wait = bus_as_ ? 0 : acc_wait + 1;
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0, n_err = 0;
  int done0, we0, req0, as0, bw0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic begin_xfer(input logic d, input logic [BAW-1:0] bb, input logic [SAW-1:0] sb,
                            input logic [SAW:0] n);
    tick();
    for (int k = 0; k < SpmWords; k++) spm_ref[k] = spm_mem[k];
    done0 = done_cnt; we0 = we_cnt; req0 = req_cyc; as0 = as_starts; bw0 = bw_addr.size();
    dir = d; bus_base = bb; spm_base = sb; len = n; start = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget, output int lat);
    lat = 0;
    while (done_cnt == done0 && lat < budget) begin
      tick();
      start = 1'b0;
      lat++;
    end
    check({tag, " done seen"}, 32'(done_cnt > done0), 32'd1);
    repeat (3) tick();
  endtask

  task automatic verify(input string tag, input logic d, input logic [BAW-1:0] bb,
                        input logic [SAW-1:0] sb, input int n_eff, input logic exp_err,
                        input logic exp_req);
    int diff, bmis;
    logic [BAW-1:0] ea;
    logic [SAW-1:0] sa;
    diff = 0; bmis = 0;
    if (!d) begin
      for (int i = 0; i < n_eff; i++) begin
        ea = bb + BAW'(i);
        sa = sb + SAW'(i);
        spm_ref[sa] = bus_val(ea);
      end
    end
    for (int k = 0; k < SpmWords; k++) if (spm_mem[k] !== spm_ref[k]) diff++;
    check({tag, " spm words differing"}, 32'(diff), 32'd0);
    check({tag, " spm_we cycles"}, 32'(we_cnt - we0), d ? 32'd0 : 32'(n_eff));
    check({tag, " bus writes"}, 32'(bw_addr.size() - bw0), d ? 32'(n_eff) : 32'd0);
    if (d) begin
      for (int i = 0; i < n_eff; i++) begin
        ea = bb + BAW'(i);
        sa = sb + SAW'(i);
        if (bw0 + i >= bw_addr.size()) bmis++;
        else if (bw_addr[bw0 + i] !== ea || bw_data[bw0 + i] !== spm_ref[sa]) bmis++;
      end
    end
    check({tag, " bus write mismatches"}, 32'(bmis), 32'd0);
    check({tag, " done pulses"}, 32'(done_cnt - done0), 32'd1);
    check({tag, " err"}, 32'(err), 32'(exp_err));
    check({tag, " bus_req used"}, 32'(req_cyc > req0), 32'(exp_req));
    check({tag, " idle outputs"}, 32'({busy, bus_req, bus_as_, spm_we}), 32'b0010);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, steps, n;
    logic d;
    logic [BAW-1:0] bb;
    logic [SAW-1:0] sb;

    salt = $urandom();
    for (int k = 0; k < SpmWords; k++) spm_shadow[k] = $urandom();
    load_en = 1'b1;
    tick();
    tick();
    load_en = 1'b0;

    // Reset state
    check("rst busy/done/err", 32'({busy, done, err}), 32'd0);
    check("rst bus_req/spm_we", 32'({bus_req, spm_we}), 32'd0);
    check("rst bus_as_/bus_rw", 32'({bus_as_, bus_rw}), 32'b11);
    check("rst bus_addr", 32'(bus_addr), 32'd0);
    check("rst spm_addr", 32'(spm_addr), 32'd0);
    check("rst data regs", bus_wr_data | spm_wr_data, 32'd0);
    reset = 1'b1;
    tick();

    // bus->SPM, grant after 2 cycles, ready in the first access cycle
    grnt_delay = 2; rdy_delay = 0;
    begin_xfer(1'b0, 30'h100, 12'h010, 13'd3);
    wait_done("b2s", 500, lat);
    verify("b2s", 1'b0, 30'h100, 12'h010, 3, 1'b0, 1'b1);

    // SPM->bus across the SPM wrap point
    grnt_delay = 1; rdy_delay = 1;
    begin_xfer(1'b1, 30'h200, 12'hFFE, 13'd3);
    wait_done("s2b wrap", 500, lat);
    verify("s2b wrap", 1'b1, 30'h200, 12'hFFE, 3, 1'b0, 1'b1);

    // Zero length: done two cycles after start, no bus request
    begin_xfer(1'b0, 30'h300, 12'h100, 13'd0);
    wait_done("len0", 50, lat);
    check("len0 latency", 32'(lat), 32'd2);
    verify("len0", 1'b0, 30'h300, 12'h100, 0, 1'b0, 1'b0);

    // Abort during the second beat of a len=8 read with slow ready
    grnt_delay = 1; rdy_delay = 3;
    begin_xfer(1'b0, 30'h400, 12'h200, 13'd8);
    steps = 0;
    while (as_starts - as0 < 2 && steps < 200) begin
      tick();
      start = 1'b0;
      steps++;
    end
    check("abort reached beat 2", 32'(as_starts - as0), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done("abort", 500, lat);
    repeat (5) tick();
    check("abort address strobes", 32'(as_starts - as0), 32'd2);
    verify("abort", 1'b0, 30'h400, 12'h200, 2, 1'b1, 1'b1);

    // start while busy is ignored
    grnt_delay = 0; rdy_delay = 2;
    begin_xfer(1'b0, 30'h500, 12'h300, 13'd4);
    tick();
    start = 1'b0;
    tick();
    dir = 1'b1; bus_base = 30'h777; spm_base = 12'h055; len = 13'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy start", 500, lat);
    verify("busy start", 1'b0, 30'h500, 12'h300, 4, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a bus access
    rdy_delay = 20;
    begin_xfer(1'b0, 30'h600, 12'h400, 13'd5);
    steps = 0;
    while (as_starts == as0 && steps < 200) begin
      tick();
      start = 1'b0;
      steps++;
    end
    check("rst mid reached access", 32'(as_starts > as0), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst mid async outputs", 32'({bus_as_, bus_req, busy}), 32'b100);
    tick();
    tick();
    reset = 1'b1;
    rdy_delay = 1;
    begin_xfer(1'b1, 30'h700, 12'h0F0, 13'd4);
    wait_done("after rst", 500, lat);
    verify("after rst", 1'b1, 30'h700, 12'h0F0, 4, 1'b0, 1'b1);

    // Randomized transfers, bus bases sometimes right below the bus wrap point
    for (int t = 0; t < 8; t++) begin
      d = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 20);
      sb = SAW'($urandom());
      bb = ($urandom_range(0, 1) == 1) ? BAW'(30'h3FFF_FFF0 + 30'($urandom_range(0, 15)))
                                       : BAW'($urandom());
      grnt_delay = $urandom_range(0, 3);
      rdy_delay = $urandom_range(0, 3);
      begin_xfer(d, bb, sb, 13'(n));
      wait_done($sformatf("rand%0d", t), 2000, lat);
      verify($sformatf("rand%0d", t), d, bb, sb, n, 1'b0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
